// File: rtl/alu_pkg.sv
// Shared defaults and FSM encoding for the ALU opcode sweep driver.
package alu_pkg;
  localparam int ALU_DATA_W = 8;
  localparam int ALU_SEL_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_OUT,
    S_DONE
  } state_t;
endpackage

// File: rtl/alu_sweep_driver_if.sv
// Result stream of the sweep driver: valid/ready with data and opcode tag.
interface alu_sweep_driver_if
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W
);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [SEL_W-1:0]  res_sel;

  modport master (
    output res_valid,
    output res_data,
    output res_sel,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_sel,
    output res_ready
  );
endinterface

// File: rtl/alu_sweep_driver.sv
// Drives an external ALU through every opcode for one operand pair and
// streams each settled result out over a valid/ready channel.
module alu_sweep_driver
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [SEL_W-1:0]  ALU_Sel,
  input  logic [DATA_W-1:0] ALU_Out,
  alu_sweep_driver_if.master res,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic load, inc, cap, adv, xfer;

  assign xfer = res.res_valid & res.res_ready;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    inc     = 1'b0;
    cap     = 1'b0;
    adv     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt == LAST) begin
          cap     = 1'b1;
          state_n = S_OUT;
        end else begin
          inc = 1'b1;
        end
      end
      S_OUT: begin
        if (xfer) begin
          if (ALU_Sel == SEL_MAX) begin
            state_n = S_DONE;
          end else begin
            adv     = 1'b1;
            state_n = S_SETTLE;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operands and opcode only move on load/advance, so a stalled
  // consumer sees everything frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A             <= '0;
      B             <= '0;
      ALU_Sel       <= '0;
      cnt           <= '0;
      res.res_data  <= '0;
      res.res_sel   <= '0;
      res.res_valid <= 1'b0;
    end else begin
      if (load) begin
        A       <= op_a;
        B       <= op_b;
        ALU_Sel <= '0;
        cnt     <= '0;
      end
      if (inc) cnt <= cnt + 1'b1;
      if (cap) begin
        res.res_data  <= ALU_Out;
        res.res_sel   <= ALU_Sel;
        res.res_valid <= 1'b1;
      end
      if (xfer) res.res_valid <= 1'b0;
      if (adv) begin
        ALU_Sel <= ALU_Sel + 1'b1;
        cnt     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_sweep_driver.sv
// Self-checking bench: directed and randomized opcode sweeps checked
// against a plain ALU reference and cycle-count expectations.
module tb_alu_sweep_driver;
  logic clk = 1'b0;
  logic rst;
  logic start0, start1;
  logic [7:0] op_a0, op_b0, op_a1, op_b1;
  logic [7:0] A0, B0, A1, B1, out0, out1;
  logic [3:0] sel0, sel1;
  logic busy0, done0, busy1, done1;
  int checks = 0;
  int errors = 0;

  alu_sweep_driver_if #(.DATA_W(8), .SEL_W(4)) rif0 ();
  alu_sweep_driver_if #(.DATA_W(8), .SEL_W(4)) rif1 ();

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] a, b,
                                     input logic [3:0] s);
    case (s)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a * b;
      4'd3:  return (b == 8'd0) ? 8'hff : a / b;
      4'd4:  return a << 1;
      4'd5:  return a >> 1;
      4'd6:  return {a[6:0], a[7]};
      4'd7:  return {a[0], a[7:1]};
      4'd8:  return a & b;
      4'd9:  return a | b;
      4'd10: return a ^ b;
      4'd11: return ~(a | b);
      4'd12: return ~(a & b);
      4'd13: return ~(a ^ b);
      4'd14: return (a > b) ? 8'd1 : 8'd0;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  assign out0 = alu(A0, B0, sel0);
  assign out1 = alu(A1, B1, sel1);

  alu_sweep_driver #(.DATA_W(8), .SEL_W(4), .SETTLE(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .op_a(op_a0), .op_b(op_b0),
    .A(A0), .B(B0), .ALU_Sel(sel0), .ALU_Out(out0),
    .res(rif0.master), .busy(busy0), .done(done0)
  );

  alu_sweep_driver #(.DATA_W(8), .SEL_W(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .op_a(op_a1), .op_b(op_b1),
    .A(A1), .B(B1), .ALU_Sel(sel1), .ALU_Out(out1),
    .res(rif1.master), .busy(busy1), .done(done1)
  );

  assign rif1.res_ready = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sweep on dut0. done_edge < 0 skips the latency check.
  task automatic sweep(input logic [7:0] a, b, input int stall_at,
                       input int stall_n, input bit rnd,
                       input int done_edge, input bit poke);
    int k = 0;
    int got = 0;
    int stalls = 0;
    bit fin = 0;
    bit poked = 0;
    bit pv = 0;
    bit pr = 1;
    logic [7:0] pd = '0;
    logic [3:0] ps = '0;
    @(negedge clk);
    op_a0 = a;
    op_b0 = b;
    start0 = 1'b1;
    rif0.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    while (!fin && k < 600) begin
      start0 = 1'b0;
      chk("A_stable", 32'(A0), 32'(a));
      chk("B_stable", 32'(B0), 32'(b));
      chk("busy", 32'(busy0), 32'd1);
      if (pv && !pr) begin
        chk("hold_valid", 32'(rif0.res_valid), 32'd1);
        chk("hold_data", 32'(rif0.res_data), 32'(pd));
        chk("hold_sel", 32'(rif0.res_sel), 32'(ps));
        chk("hold_alu_sel", 32'(sel0), 32'(ps));
      end
      if (rif0.res_valid && stall_at >= 0 &&
          32'(rif0.res_sel) == stall_at && stalls < stall_n) begin
        rif0.res_ready = 1'b0;
        stalls++;
      end else if (rnd) begin
        rif0.res_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rif0.res_ready = 1'b1;
      end
      if (rif0.res_valid && rif0.res_ready) begin
        chk("res_sel", 32'(rif0.res_sel), 32'(got));
        chk("res_data", 32'(rif0.res_data), 32'(alu(a, b, 4'(got))));
        got++;
      end
      if (poke && !poked && rif0.res_valid && rif0.res_sel == 4'd7) begin
        op_a0 = 8'd1;
        start0 = 1'b1;
        poked = 1;
      end
      if (done0) begin
        fin = 1;
        if (done_edge >= 0) chk("done_edge", 32'(k), 32'(done_edge));
      end
      pv = rif0.res_valid;
      pr = rif0.res_ready;
      pd = rif0.res_data;
      ps = rif0.res_sel;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    start0 = 1'b0;
    chk("done_seen", 32'(fin), 32'd1);
    chk("result_count", 32'(got), 32'd16);
    chk("done_pulse_once", 32'(done0), 32'd0);
    chk("idle_busy", 32'(busy0), 32'd0);
    chk("idle_A", 32'(A0), 32'(a));
    chk("idle_B", 32'(B0), 32'(b));
    chk("idle_sel", 32'(sel0), 32'd15);
    rif0.res_ready = 1'b1;
  endtask

  initial begin
    int k;
    int got;
    bit fin;
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a0 = '0;
    op_b0 = '0;
    op_a1 = '0;
    op_b1 = '0;
    rif0.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_A", 32'(A0), 32'd0);
    chk("rst_sel", 32'(sel0), 32'd0);
    chk("rst_valid", 32'(rif0.res_valid), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    sweep(8'd40, 8'd20, -1, 0, 0, 48, 0);
    sweep(8'd40, 8'd20, 3, 5, 0, 53, 1);

    // Asynchronous reset in the middle of opcode 9.
    @(negedge clk);
    op_a0 = 8'd40;
    op_b0 = 8'd20;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    k = 0;
    while (sel0 != 4'd9 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_sel9", 32'(sel0), 32'd9);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_A", 32'(A0), 32'd0);
    chk("mid_rst_B", 32'(B0), 32'd0);
    chk("mid_rst_sel", 32'(sel0), 32'd0);
    chk("mid_rst_valid", 32'(rif0.res_valid), 32'd0);
    chk("mid_rst_data", 32'(rif0.res_data), 32'd0);
    chk("mid_rst_rsel", 32'(rif0.res_sel), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_resume_busy", 32'(busy0), 32'd0);
    chk("no_resume_valid", 32'(rif0.res_valid), 32'd0);
    sweep(8'd5, 8'd3, -1, 0, 0, 48, 0);

    repeat (3) begin
      sweep(8'($urandom), 8'($urandom), -1, 0, 1, -1, 0);
    end

    // SETTLE=1 instance: two cycles per opcode.
    @(negedge clk);
    op_a1 = 8'($urandom);
    op_b1 = 8'($urandom);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    got = 0;
    fin = 0;
    while (!fin && k < 200) begin
      if (rif1.res_valid) begin
        chk("s1_sel", 32'(rif1.res_sel), 32'(got));
        chk("s1_data", 32'(rif1.res_data), 32'(alu(op_a1, op_b1, 4'(got))));
        got++;
      end
      if (done1) begin
        chk("s1_done_edge", 32'(k), 32'd32);
        fin = 1;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk("s1_done_seen", 32'(fin), 32'd1);
    chk("s1_count", 32'(got), 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_sweep_driver.md
ALU_SWEEP_DRIVER -- requirements
Module: alu_sweep_driver

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning operand/result width.
REQ-002 The block SHALL have parameter SEL_W, default 4, meaning opcode width; it sweeps 2**SEL_W opcodes.
REQ-003 The block SHALL have parameter SETTLE, default 2, meaning cycles from operand/opcode drive to result sample; legal range >= 1.
REQ-004 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, is the reset; it is asynchronous and active-high.
REQ-006 Port start, input, 1, requests one opcode sweep.
REQ-007 Ports op_a and op_b, input, DATA_W each, are the operands for the sweep.
REQ-008 Ports A and B, output, DATA_W each, drive the ALU operands.
REQ-009 Port ALU_Sel, output, SEL_W, drives the ALU opcode.
REQ-010 Port ALU_Out, input, DATA_W, is the ALU result.
REQ-011 Ports res_valid (output, 1), res_ready (input, 1), res_data (output, DATA_W) and res_sel (output, SEL_W) form the result stream.
REQ-012 Port busy, output, 1, is high outside IDLE.
REQ-013 Port done, output, 1, is a one-cycle sweep-complete pulse.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, OUT and DONE.
REQ-015 IDLE: when start=1, the block SHALL register A<=op_a, B<=op_b, ALU_Sel<=0 and cnt<=0, then go to SETTLE.
REQ-016 SETTLE: when cnt==SETTLE-1, the block SHALL register res_data<=ALU_Out and res_sel<=ALU_Sel, set res_valid<=1 and go to OUT; otherwise it SHALL increment cnt.
REQ-017 OUT: a transfer occurs only on an edge where res_valid=1 and res_ready=1; on transfer the block SHALL clear res_valid.
REQ-018 OUT: on transfer with ALU_Sel == 2**SEL_W-1, the block SHALL go to DONE; on any other transfer it SHALL increment ALU_Sel, clear cnt and go to SETTLE.
REQ-019 While res_valid=1 and res_ready=0, res_data, res_sel, A, B and ALU_Sel SHALL hold unchanged (unbounded stall).
REQ-020 DONE: the block SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 start SHALL be ignored when busy=1.
REQ-022 A, B and ALU_Sel SHALL be stable for the whole sweep and SHALL retain their final values in IDLE after the sweep.
REQ-023 With res_ready held high, each opcode SHALL take SETTLE+1 cycles; for a sweep started at edge 0, done SHALL be high in the cycle after edge 16*(SETTLE+1).
REQ-024 ALU_Out SHALL be sampled unmodified (no width change); ALU_Sel SHALL never wrap within a sweep.
REQ-025 res_valid SHALL NOT depend combinationally on res_ready.

Reset
REQ-026 rst=1 SHALL immediately force the state to IDLE and set A, B, ALU_Sel, cnt, res_data, res_sel, res_valid, busy and done to 0, including mid-sweep.
REQ-027 After rst deasserts, the block SHALL require a fresh start; an interrupted sweep SHALL NOT resume.

Structure
REQ-028 Shared package alu_pkg SHALL hold DATA_W/SEL_W defaults and the FSM state enum (2-bit).
REQ-029 The block SHALL be one module with no sub-modules; cnt width SHALL be $clog2(SETTLE+1).

Verification
REQ-030 op_a=40, op_b=20, SETTLE=2, res_ready=1, start pulse -> 16 results with res_sel 0..15 in order, each res_data equal to the ALU model output for that opcode; done high in the cycle after edge 48.
REQ-031 Same stimulus with res_ready=0 for 5 cycles while res_sel=3 -> res_data, res_sel and ALU_Sel=3 hold for those 5 cycles; no result is lost or duplicated.
REQ-032 start pulsed again at opcode 7 with op_a=1 -> ignored; A stays 40 and the sweep completes normally.
REQ-033 rst asserted asynchronously mid-cycle at opcode 9 -> all outputs read 0 before the next edge; the next start with op_a=5 and op_b=3 yields a full sweep from res_sel=0.
REQ-034 SETTLE=1, res_ready=1 -> 2 cycles per opcode; done in the cycle after edge 32.
